midi_tx: RTL and testbench
==========================

Name: midi_tx

Overview:
MIDI serial transmitter, the transmit counterpart of the MIDI receive path. Accepts note-on/note-off events over a valid/ready handshake and serializes them as 3-byte (or 2-byte with running status) MIDI messages. Output is 8N1 at 31250 baud on a single line for a board GPIO. Runs on the 25 MHz system clock. Used for MIDI thru/echo and for driving external synths.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 31250, serial bit rate
RUNNING_STATUS, 1, 1 = omit status byte when equal to last transmitted status; 0 = always send status

Ports:
i_clk  input  1  system clock, 25 MHz
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  event request; fields below are valid while high
o_ready  output  1  block can accept an event this cycle
i_note_on  input  1  1 = note-on (status 0x9n), 0 = note-off (status 0x8n)
i_channel  input  4  MIDI channel n, 0..15
i_note  input  7  note number, 0..127
i_velocity  input  7  velocity, 0..127
o_midi_tx  output  1  serial MIDI line, idle high
o_busy  output  1  high while a message is being serialized
o_byte_done  output  1  one-cycle pulse at the end of each byte's stop bit

Behaviour:
- Reset (async assert, sync release): o_midi_tx=1, o_ready=1, o_busy=0, o_byte_done=0, state IDLE, last_status=0x00 (invalid, forces next status send). Reset mid-frame truncates immediately. Line goes high in the same instant, with no partial stop bit.
- Bit timing: CLKS_PER_BIT = CLK_HZ/BAUD (800 at defaults). Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles. A baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every bit boundary.
- Frame: start bit 0, data bits D0..D7 (LSB first), stop bit 1. 10 bits per byte.
- Message bytes: status = {3'b100, i_note_on, i_channel}. Data1 = {1'b0, i_note}. Data2 = {1'b0, i_velocity}.
- Running status: if RUNNING_STATUS=1 and the computed status equals last_status, the status byte is skipped and the message is Data1 and Data2 only. last_status updates whenever a status byte is sent.
- Handshake: o_ready = (state==IDLE). An event is accepted on a cycle with i_valid && o_ready. All fields are latched on that cycle and later changes to the inputs are ignored. o_ready drops the next cycle.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte of the same message) or IDLE (last byte), after CLKS_PER_BIT cycles.
- Latency: o_midi_tx goes low (start bit) on the cycle after accept, because the output is registered. o_busy is high from that cycle until the final stop bit ends.
- Bytes within a message are back-to-back: the next start bit immediately follows the stop bit, with no idle gap.
- o_byte_done pulses on the last cycle of each stop bit: 3 pulses per full message, 2 with running status.
- End of message: IDLE is entered and o_ready=1 on the cycle after the last stop bit's final cycle. If i_valid is held high, the next event is accepted that cycle, which gives exactly 1 extra idle-high cycle between messages.
- Message duration: full message = 30*CLKS_PER_BIT cycles (24000). Running-status message = 20*CLKS_PER_BIT cycles (16000).
- i_valid while busy: ignored, not queued. The requester must hold it until o_ready.

Test Plan:
- Reset then idle 1000 cycles -> o_midi_tx=1, o_ready=1, o_busy=0 throughout.
- Note-on, ch 0, note 60, vel 100 -> bytes 0x90, 0x3C, 0x64. Start bit begins 1 cycle after accept. Each bit is 800 cycles wide. 3 o_byte_done pulses. o_ready returns 24001 cycles after accept.
- Same event repeated with RUNNING_STATUS=1 -> only 0x3C, 0x64 sent, in 16000 cycles. With RUNNING_STATUS=0 -> full 0x90, 0x3C, 0x64.
- Note-on ch 0 then note-off ch 0, note 60, vel 0 -> second message resends status 0x80. A later note-off ch 3 sends 0x83.
- i_valid held high with changing fields during transmission -> fields latched at accept. Next event accepted exactly 1 cycle after the final stop bit. Inter-message line gap is 1 idle-high cycle.
- Assert i_rst_n=0 mid data bit of the 2nd byte -> o_midi_tx=1 asynchronously. After release o_ready=1, and the next identical event sends the full 3 bytes because last_status was cleared.

Source files
------------

// File: rtl/midi_tx.sv
// MIDI transmitter: takes note-on/off events over valid/ready and sends them as
// 8N1 serial bytes, omitting a repeated status byte when running status is on.
module midi_tx #(
   parameter int CLK_HZ         = 25000000,
   parameter int BAUD           = 31250,
   parameter bit RUNNING_STATUS = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic       i_note_on,
   input  logic [3:0] i_channel,
   input  logic [6:0] i_note,
   input  logic [6:0] i_velocity,
   output logic       o_midi_tx,
   output logic       o_busy,
   output logic       o_byte_done
);

   // state | meaning
   // IDLE  | line high, ready for an event
   // START | start bit (low) of the current byte
   // DATA  | data bits D0..D7, LSB first
   // STOP  | stop bit (high); chains to START for the next byte or to IDLE
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [7:0]       sh_q, sh_d;
   logic [6:0]       d1_q, d1_d;
   logic [6:0]       d2_q, d2_d;
   logic [7:0]       last_status_q, last_status_d;
   logic             tx_q, tx_d;

   logic       bit_end;
   logic [7:0] status;
   logic       send_status;

   assign bit_end     = (baud_q == CNT_LAST);
   assign status      = {3'b100, i_note_on, i_channel};
   assign send_status = !RUNNING_STATUS || (status != last_status_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         baud_q        <= '0;
         bit_q         <= '0;
         byte_q        <= '0;
         sh_q          <= '0;
         d1_q          <= '0;
         d2_q          <= '0;
         last_status_q <= 8'h00;
         tx_q          <= 1'b1;
      end else begin
         state_q       <= state_d;
         baud_q        <= baud_d;
         bit_q         <= bit_d;
         byte_q        <= byte_d;
         sh_q          <= sh_d;
         d1_q          <= d1_d;
         d2_q          <= d2_d;
         last_status_q <= last_status_d;
         tx_q          <= tx_d;
      end
   end

   // tx_d always carries the line level of the state being entered, so the
   // registered output lines up with the state register.
   always_comb begin
      state_d       = state_q;
      baud_d        = baud_q;
      bit_d         = bit_q;
      byte_d        = byte_q;
      sh_d          = sh_q;
      d1_d          = d1_q;
      d2_d          = d2_q;
      last_status_d = last_status_q;
      tx_d          = tx_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (i_valid) begin
               d1_d    = i_note;
               d2_d    = i_velocity;
               state_d = START;
               tx_d    = 1'b0;
               if (send_status) begin
                  sh_d          = status;
                  byte_d        = 2'd0;
                  last_status_d = status;
               end else begin
                  sh_d   = {1'b0, i_note};
                  byte_d = 2'd1;
               end
            end
         end
         START: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               state_d = DATA;
               bit_d   = 3'd0;
               tx_d    = sh_q[0];
            end
         end
         DATA: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               sh_d = {1'b1, sh_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = sh_q[1];
               end
            end
         end
         STOP: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               if (byte_q == 2'd2) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  sh_d    = (byte_q == 2'd0) ? {1'b0, d1_q} : {1'b0, d2_q};
                  state_d = START;
                  tx_d    = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_ready     = (state_q == IDLE);
   assign o_busy      = (state_q != IDLE);
   assign o_byte_done = (state_q == STOP) && bit_end;
   assign o_midi_tx   = tx_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (running status on/off) at 16 clocks per bit,
// line captured cycle by cycle and decoded against hand-computed bytes.
module tb_midi_tx;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       note_on = 1'b0;
   logic [3:0] ch = '0;
   logic [6:0] note = '0, vel = '0;
   logic       rdy_a, tx_a, busy_a, done_a;
   logic       rdy_b, tx_b, busy_b, done_b;

   int n_chk = 0;
   int n_fail = 0;

   midi_tx #(.CLK_HZ(500000), .BAUD(31250), .RUNNING_STATUS(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(rdy_a),
      .i_note_on(note_on), .i_channel(ch), .i_note(note), .i_velocity(vel),
      .o_midi_tx(tx_a), .o_busy(busy_a), .o_byte_done(done_a));

   midi_tx #(.CLK_HZ(500000), .BAUD(31250), .RUNNING_STATUS(1'b0)) dut_nrs (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(rdy_b),
      .i_note_on(note_on), .i_channel(ch), .i_note(note), .i_velocity(vel),
      .o_midi_tx(tx_b), .o_busy(busy_b), .o_byte_done(done_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_tx(input bit sel);   return sel ? tx_b : tx_a;     endfunction
   function automatic logic get_rdy(input bit sel);  return sel ? rdy_b : rdy_a;   endfunction
   function automatic logic get_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
   function automatic logic get_done(input bit sel); return sel ? done_b : done_a; endfunction

   task automatic set_ev(input logic on, input logic [3:0] c, input logic [6:0] n, input logic [6:0] v);
      note_on = on;
      ch      = c;
      note    = n;
      vel     = v;
   endtask

   // Called just after a negedge with valid asserted; returns just after the accepting posedge.
   task automatic wait_accept(input bit sel, output int waited);
      waited = 0;
      while (!get_rdy(sel) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check("accept_ready", 32'(get_rdy(sel)), 32'd1);
      @(posedge clk);
   endtask

   task automatic capture(input bit sel, input int nbytes,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input bit hold, input logic nx_on, input logic [3:0] nx_ch,
                          input logic [6:0] nx_n, input logic [6:0] nx_v);
      int         len;
      int         hs_err, done_cnt, done_err, frm_err, base;
      logic       ln [0:511];
      logic [7:0] exp_b [0:2];
      logic [7:0] data;
      len      = nbytes * 10 * CPB;
      hs_err   = 0;
      done_cnt = 0;
      done_err = 0;
      frm_err  = 0;
      exp_b[0] = e0;
      exp_b[1] = e1;
      exp_b[2] = e2;
      for (int c = 1; c <= len + 1; c++) begin
         @(negedge clk);
         ln[c] = get_tx(sel);
         if (c <= len && (!get_busy(sel) || get_rdy(sel))) hs_err++;
         if (get_done(sel)) begin
            done_cnt++;
            if (c % (10 * CPB) != 0) done_err++;
         end
         if (c == 1 && !hold) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
         end
         if (hold && c <= len)
            set_ev(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
         if (hold && c == len + 1) set_ev(nx_on, nx_ch, nx_n, nx_v);
      end
      check("ready_end", 32'(get_rdy(sel)), 32'd1);
      check("busy_end", 32'(get_busy(sel)), 32'd0);
      check("idle_gap_high", 32'(ln[len+1]), 32'd1);
      check("busy_during_msg", 32'(hs_err), 32'd0);
      check("byte_done_count", 32'(done_cnt), 32'(nbytes));
      check("byte_done_pos", 32'(done_err), 32'd0);
      for (int j = 0; j < nbytes; j++) begin
         data = '0;
         for (int b = 0; b < 10; b++) begin
            base = 1 + j * 10 * CPB + b * CPB;
            for (int k = 1; k < CPB; k++)
               if (ln[base+k] !== ln[base]) frm_err++;
            if (b == 0 && ln[base] !== 1'b0) frm_err++;
            if (b == 9 && ln[base] !== 1'b1) frm_err++;
            if (b >= 1 && b <= 8) data[b-1] = ln[base];
         end
         check($sformatf("byte%0d", j), 32'(data), 32'(exp_b[j]));
      end
      check("frame_timing", 32'(frm_err), 32'd0);
   endtask

   task automatic msg(input bit sel, input logic on, input logic [3:0] c, input logic [6:0] n,
                      input logic [6:0] v, input int nbytes,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
      int w;
      @(negedge clk);
      set_ev(on, c, n, v);
      if (sel) valid_b = 1'b1;
      else     valid_a = 1'b1;
      wait_accept(sel, w);
      capture(sel, nbytes, e0, e1, e2, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, idle_err;
      repeat (3) @(negedge clk);
      check("rst_line", 32'(tx_a), 32'd1);
      check("rst_ready", 32'(rdy_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      rst_n = 1'b1;
      idle_err = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1) idle_err++;
      end
      check("idle_1000", 32'(idle_err), 32'd0);

      // Full message, then the same event under running status.
      msg(1'b0, 1'b1, 4'd0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64);
      msg(1'b0, 1'b1, 4'd0, 7'd60, 7'd100, 2, 8'h3C, 8'h64, 8'h00);
      // Running status disabled: status always resent.
      msg(1'b1, 1'b1, 4'd0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64);
      msg(1'b1, 1'b1, 4'd0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64);
      // Status changes force a resend.
      msg(1'b0, 1'b0, 4'd0, 7'd60, 7'd0, 3, 8'h80, 8'h3C, 8'h00);
      msg(1'b0, 1'b0, 4'd3, 7'h45, 7'h7F, 3, 8'h83, 8'h45, 8'h7F);

      // valid held high with scrambled fields; next event chained with one idle cycle.
      @(negedge clk);
      set_ev(1'b1, 4'd5, 7'h12, 7'h34);
      valid_a = 1'b1;
      wait_accept(1'b0, w);
      capture(1'b0, 3, 8'h95, 8'h12, 8'h34, 1'b1, 1'b1, 4'd5, 7'h56, 7'h01);
      wait_accept(1'b0, w);
      check("chain_accept_wait", 32'(w), 32'd0);
      capture(1'b0, 2, 8'h56, 8'h01, 8'h00, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0);

      // Reset during D2 (low) of the second byte, 0x12.
      @(negedge clk);
      set_ev(1'b0, 4'd5, 7'h12, 7'h34);
      valid_a = 1'b1;
      wait_accept(1'b0, w);
      for (int c = 1; c <= 1 + 10 * CPB + 3 * CPB + CPB / 2; c++) begin
         @(negedge clk);
         valid_a = 1'b0;
      end
      check("pre_rst_line", 32'(tx_a), 32'd0);
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_line", 32'(tx_a), 32'd1);
      check("async_rst_ready", 32'(rdy_a), 32'd1);
      check("async_rst_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(rdy_a), 32'd1);
      check("post_rst_line", 32'(tx_a), 32'd1);
      msg(1'b0, 1'b0, 4'd5, 7'h12, 7'h34, 3, 8'h85, 8'h12, 8'h34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
